// File: rtl/fdc_decimator.sv
// fdc_decimator: block-sum decimator behind the frequency-to-digital converter.
// Sums blocks of 2^dec_sel converter samples and presents each finished block
// as a raw sum plus a truncated mean. Results sit in a valid/ready holding
// register, and a sticky flag records any block that had to be thrown away.
module fdc_decimator #(
    parameter int  IN_W      = 5,
    parameter int  LOG2_NMAX = 5,
    localparam int OUT_W     = IN_W + LOG2_NMAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       dec_sel,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [OUT_W-1:0] out_sum,
    output logic [IN_W-1:0]  out_mean,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    // The sample counter must be able to hold 2^LOG2_NMAX itself, one bit wider
    // than the selector range.
    localparam int CNT_W = LOG2_NMAX + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [2:0]       SEL_MAX = 3'(LOG2_NMAX);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [0:0]       r_state;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_blk_sel;
    logic [OUT_W-1:0] r_out_sum;
    logic [IN_W-1:0]  r_out_mean;
    logic             r_out_valid;
    logic             r_overrun;

    // Decode of the current cycle
    logic [2:0]       w_sel_clamped;
    logic             w_in_accum;
    logic             w_start;
    logic             w_abort;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_blk_len;
    logic             w_done;
    logic [OUT_W-1:0] w_in_ext;
    logic [OUT_W-1:0] w_result;
    logic [IN_W-1:0]  w_mean;
    logic             w_consume;
    logic             w_load;
    logic             w_drop;

    // Selectors above the largest supported block length behave as the largest.
    assign w_sel_clamped = (dec_sel > SEL_MAX) ? SEL_MAX : dec_sel;

    assign w_in_accum = (r_state == ST_ACCUM);
    assign w_start    = !w_in_accum && enable;
    assign w_abort    = w_in_accum && !enable;

    // A sample is only taken while accumulating and still enabled; a strobe that
    // arrives together with the abort is ignored.
    assign w_accept   = w_in_accum && enable && in_valid;

    // Block ends when the sample being accepted is the 2^blk_sel-th one, so the
    // comparison uses the post-increment count.
    assign w_cnt_next = r_cnt + CNT_ONE;
    assign w_blk_len  = CNT_ONE << r_blk_sel;
    assign w_done     = w_accept && (w_cnt_next == w_blk_len);

    // The final sample is folded into the result directly so the block closes on
    // the same edge that accepts it.
    assign w_in_ext   = {{LOG2_NMAX{1'b0}}, in_data};
    assign w_result   = r_acc + w_in_ext;

    // Dividing by the block length is a right shift; the quotient of a full
    // block never exceeds the largest sample, so IN_W bits always suffice.
    assign w_mean     = IN_W'(w_result >> r_blk_sel);

    // Output handshake. A result finishing while the consumer takes the old one
    // replaces it without a gap; finishing while the old one is still pending
    // loses the new block.
    assign w_consume  = r_out_valid && out_ready;
    assign w_load     = w_done && (!r_out_valid || out_ready);
    assign w_drop     = w_done && r_out_valid && !out_ready;

    // Control FSM: enable starts accumulation, dropping enable abandons it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (w_start) begin
            r_state <= ST_ACCUM;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
        end
    end

    // Running sum and sample count; cleared at every block start, end or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_start || w_abort || w_done) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_result;
            r_cnt <= w_cnt_next;
        end
    end

    // Block length is captured only at block boundaries so mid-block selector
    // changes cannot corrupt the block in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_sel <= '0;
        end else if (w_start || w_done) begin
            r_blk_sel <= w_sel_clamped;
        end
    end

    // Holding register for the latest result; contents stay frozen until loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_sum   <= '0;
            r_out_mean  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_sum   <= w_result;
            r_out_mean  <= w_mean;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_sum   = r_out_sum;
    assign out_mean  = r_out_mean;
    assign out_valid = r_out_valid;
    assign busy      = w_in_accum;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fdc_decimator.sv
// tb_fdc_decimator: directed table, corner-case sequences and random traffic
// for the block-sum decimator, checked against a queue-based reference model.
module tb_fdc_decimator;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] decSel;
    logic [4:0] inData;
    logic       inValid;
    logic       outReady;
    logic       overrunClr;
    logic [9:0] outSum;
    logic [4:0] outMean;
    logic       outValid;
    logic       busy;
    logic       overrun;

    int checks;
    int passed;

    // Reference model: a block is just the list of samples taken since it began.
    bit  mActive;
    int  mSel;
    int  mSamples[$];
    bit  mOutValid;
    int  mOutSum;
    int  mOutMean;
    bit  mOverrun;

    typedef struct {
        bit         en;
        logic [2:0] sel;
        logic [4:0] data;
        bit         valid;
        bit         ready;
        bit         clr;
        bit         expValid;
        int         expSum;
        int         expMean;
        bit         expBusy;
        bit         expOvr;
    } vecT;

    vecT vecs[$];

    fdc_decimator dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dec_sel    (decSel),
        .in_data    (inData),
        .in_valid   (inValid),
        .out_ready  (outReady),
        .overrun_clr(overrunClr),
        .out_sum    (outSum),
        .out_mean   (outMean),
        .out_valid  (outValid),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampSel(input int s);
        return (s > 5) ? 5 : s;
    endfunction

    // One clock of the model, computed from the inputs about to be sampled.
    task automatic modelStep(input bit rst, input bit en, input int sel,
                             input int data, input bit valid, input bit ready,
                             input bit clr);
        bit consume;
        bit loaded;
        bit dropped;
        int len;
        int sum;
        consume = mOutValid && ready;
        loaded  = 1'b0;
        dropped = 1'b0;
        if (rst) begin
            mActive   = 1'b0;
            mSel      = 0;
            mSamples.delete();
            mOutValid = 1'b0;
            mOutSum   = 0;
            mOutMean  = 0;
            mOverrun  = 1'b0;
            return;
        end
        if (!mActive) begin
            if (en) begin
                mActive = 1'b1;
                mSamples.delete();
                mSel = clampSel(sel);
            end
        end else if (!en) begin
            mActive = 1'b0;
            mSamples.delete();
        end else if (valid) begin
            mSamples.push_back(data);
            len = 1 << mSel;
            if (mSamples.size() == len) begin
                sum = 0;
                foreach (mSamples[k]) sum += mSamples[k];
                if (mOutValid && !ready) begin
                    dropped = 1'b1;
                end else begin
                    loaded   = 1'b1;
                    mOutSum  = sum;
                    mOutMean = sum / len;
                end
                mSamples.delete();
                mSel = clampSel(sel);
            end
        end
        if (loaded) mOutValid = 1'b1;
        else if (consume) mOutValid = 1'b0;
        if (dropped) mOverrun = 1'b1;
        else if (clr) mOverrun = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and step past the edge.
    task automatic applyStimulus(input bit rst, input bit en, input logic [2:0] sel,
                                 input logic [4:0] data, input bit valid,
                                 input bit ready, input bit clr);
        reset      = rst;
        enable     = en;
        decSel     = sel;
        inData     = data;
        inValid    = valid;
        outReady   = ready;
        overrunClr = clr;
        modelStep(rst, en, int'(sel), int'(data), valid, ready, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the reference model.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".out_valid"}, int'(outValid), int'(mOutValid));
        checkVal({tag, ".out_sum"},   int'(outSum),   mOutSum);
        checkVal({tag, ".out_mean"},  int'(outMean),  mOutMean);
        checkVal({tag, ".busy"},      int'(busy),     int'(mActive));
        checkVal({tag, ".overrun"},   int'(overrun),  int'(mOverrun));
    endtask

    function automatic vecT mkVec(input bit en, input int sel, input int data,
                                  input bit valid, input bit ready, input bit clr,
                                  input bit eV, input int eS, input int eM,
                                  input bit eB, input bit eO);
        vecT v;
        v.en = en; v.sel = 3'(sel); v.data = 5'(data); v.valid = valid;
        v.ready = ready; v.clr = clr; v.expValid = eV; v.expSum = eS;
        v.expMean = eM; v.expBusy = eB; v.expOvr = eO;
        return v;
    endfunction

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b1; enable = 1'b0; decSel = '0; inData = '0;
        inValid = 1'b0; outReady = 1'b0; overrunClr = 1'b0;

        // Hand-computed expectations, one row per clock:
        //          en sel dat v  rdy clr  valid sum mean busy ovr
        vecs.push_back(mkVec(1, 2, 0, 0, 1, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mkVec(1, 2, 3, 1, 1, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mkVec(1, 2, 5, 1, 1, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mkVec(1, 2, 7, 1, 1, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mkVec(1, 2, 9, 1, 1, 0,  1, 24, 6, 1, 0));
        vecs.push_back(mkVec(1, 2, 0, 0, 1, 0,  0, 24, 6, 1, 0));
        vecs.push_back(mkVec(0, 2, 0, 0, 1, 0,  0, 24, 6, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 1, 0,  0, 24, 6, 1, 0));
        vecs.push_back(mkVec(1, 0, 4, 1, 1, 0,  1,  4, 4, 1, 0));
        vecs.push_back(mkVec(1, 0, 9, 1, 1, 0,  1,  9, 9, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0,  0,  9, 9, 0, 0));
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 0,  0,  9, 9, 1, 0));
        vecs.push_back(mkVec(1, 1, 1, 1, 0, 0,  0,  9, 9, 1, 0));
        vecs.push_back(mkVec(1, 1, 1, 1, 0, 0,  1,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 1, 2, 1, 0, 0,  1,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 1, 2, 1, 0, 0,  1,  2, 1, 1, 1));
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 1,  1,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 1, 0, 0, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(0, 2, 0, 0, 1, 0,  0,  2, 1, 0, 0));
        vecs.push_back(mkVec(1, 2, 0, 0, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 7, 1, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 7, 1, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(0, 2, 7, 1, 1, 0,  0,  2, 1, 0, 0));
        vecs.push_back(mkVec(1, 2, 0, 0, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 1, 1, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 1, 1, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 1, 1, 1, 0,  0,  2, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 1, 1, 1, 0,  1,  4, 1, 1, 0));

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset");

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].valid,
                          vecs[i].ready, vecs[i].clr);
            checkVal($sformatf("vec%0d.out_valid", i), int'(outValid), int'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.out_sum", i),   int'(outSum),   vecs[i].expSum);
            checkVal($sformatf("vec%0d.out_mean", i),  int'(outMean),  vecs[i].expMean);
            checkVal($sformatf("vec%0d.busy", i),      int'(busy),     int'(vecs[i].expBusy));
            checkVal($sformatf("vec%0d.overrun", i),   int'(overrun),  int'(vecs[i].expOvr));
            checkOutput($sformatf("vec%0d.model", i));
        end

        // Full-scale block with an out-of-range selector: 32 samples of 31
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 0, 0, 1, 0);
        for (int n = 0; n < 31; n++) applyStimulus(0, 1, 7, 31, 1, 1, 0);
        checkVal("clamp.not_done_at_31", int'(outValid), 0);
        applyStimulus(0, 1, 7, 31, 1, 1, 0);
        checkVal("clamp.valid_at_32", int'(outValid), 1);
        checkVal("clamp.sum_992", int'(outSum), 992);
        checkVal("clamp.mean_31", int'(outMean), 31);
        checkOutput("clamp");

        // Overrun set wins over a simultaneous clear
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 6, 1, 0, 0);
        applyStimulus(0, 1, 0, 8, 1, 0, 1);
        checkVal("setwins.overrun", int'(overrun), 1);
        checkVal("setwins.kept_sum", int'(outSum), 6);
        checkOutput("setwins");

        // Reset in the middle of a block
        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 5, 1, 0, 0);
        applyStimulus(1, 1, 3, 5, 1, 0, 0);
        checkVal("midreset.out_valid", int'(outValid), 0);
        checkVal("midreset.out_sum", int'(outSum), 0);
        checkVal("midreset.out_mean", int'(outMean), 0);
        checkVal("midreset.busy", int'(busy), 0);
        checkVal("midreset.overrun", int'(overrun), 0);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 39) != 0,
                          3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) == 0);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
